// File: rtl/hit_collect_fifo_if.sv
// Bundle of the hit inputs and the bit-serial host port of hit_collect_fifo.
// The master modport is the hit sources plus the host; the slave modport is the FIFO.
interface hit_collect_fifo_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 100,
  parameter int DEPTH  = 8
);
  localparam int LW = $clog2(DEPTH + 2);

  logic [NUM_CH-1:0]       hit_valid;
  logic [NUM_CH*WIDTH-1:0] hit_data;
  logic                    fifo_req;
  logic                    fifo_oflow_clr;
  logic                    fifo_bit;
  logic                    fifo_empty;
  logic                    fifo_oflow;
  logic [LW-1:0]           fifo_level;

  modport master (
    output hit_valid, hit_data, fifo_req, fifo_oflow_clr,
    input  fifo_bit, fifo_empty, fifo_oflow, fifo_level
  );

  modport slave (
    input  hit_valid, hit_data, fifo_req, fifo_oflow_clr,
    output fifo_bit, fifo_empty, fifo_oflow, fifo_level
  );
endinterface

// File: rtl/hit_collect_fifo.sv
// Multi-channel hit collector: per-channel pending slots, round-robin drain into a
// DEPTH-entry RAM, and a head shift register read out MSB first, one bit per request.
module hit_collect_fifo #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 100,
  parameter int DEPTH  = 8,
  parameter int CHW    = $clog2(NUM_CH),
  parameter int EW     = CHW + WIDTH
) (
  input logic               clk,
  input logic               rst_n,
  hit_collect_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 2);
  localparam int BW = $clog2(EW);

  logic [NUM_CH-1:0] pend_v;
  logic [WIDTH-1:0]  pend_d [NUM_CH];
  logic [EW-1:0]     ram [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr, occ;
  logic              ram_full, ram_empty;
  logic [CHW-1:0]    rr_ptr, gnt_ch;
  logic              gnt_vld;
  logic [CHW:0]      srch;
  logic [NUM_CH-1:0] drain, drop;
  logic [EW-1:0]     head;
  logic              head_v, head_ld;
  logic [BW-1:0]     bit_cnt;
  logic              oflow;

  assign occ       = wr_ptr - rd_ptr;
  assign ram_empty = (wr_ptr == rd_ptr);
  assign ram_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_ld   = !head_v && !ram_empty;

  // Round-robin search starting at rr_ptr; nothing is granted while the RAM is full.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    srch    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      srch = {1'b0, rr_ptr} + (CHW+1)'(i);
      if (srch >= (CHW+1)'(NUM_CH))
        srch = srch - (CHW+1)'(NUM_CH);
      if (!gnt_vld && !ram_full && pend_v[srch[CHW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_ch  = srch[CHW-1:0];
      end
    end
  end

  always_comb begin
    drain = '0;
    if (gnt_vld)
      drain[gnt_ch] = 1'b1;
  end

  // A slot being drained this cycle can take a new hit without a drop.
  assign drop = bus.hit_valid & pend_v & ~drain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pend_v <= '0;
    else
      pend_v <= (pend_v & ~drain) | bus.hit_valid;
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.hit_valid[c] && (!pend_v[c] || drain[c]))
        pend_d[c] <= bus.hit_data[c*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (gnt_vld)
      ram[wr_ptr[AW-1:0]] <= {gnt_ch, pend_d[gnt_ch]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rr_ptr  <= '0;
      oflow   <= 1'b0;
      head    <= '0;
      head_v  <= 1'b0;
      bit_cnt <= '0;
    end else begin
      if (gnt_vld) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= (gnt_ch == CHW'(NUM_CH - 1)) ? '0 : gnt_ch + 1'b1;
      end
      if (|drop)
        oflow <= 1'b1;
      else if (bus.fifo_oflow_clr)
        oflow <= 1'b0;
      // The final pop shifts too, so an idle head always presents fifo_bit = 0.
      if (head_ld) begin
        head   <= ram[rd_ptr[AW-1:0]];
        head_v <= 1'b1;
        rd_ptr <= rd_ptr + 1'b1;
      end else if (head_v && bus.fifo_req) begin
        head <= {head[EW-2:0], 1'b0};
        if (bit_cnt == BW'(EW - 1)) begin
          head_v  <= 1'b0;
          bit_cnt <= '0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.fifo_bit   = head[EW-1];
  assign bus.fifo_empty = !head_v;
  assign bus.fifo_oflow = oflow;
  assign bus.fifo_level = LW'(occ) + LW'(head_v);
endmodule

// File: doc/hit_collect_fifo.md
Name: hit_collect_fifo

Overview:
- Collects result words ("hits") from NUM_CH parallel hash channels and queues them in a DEPTH-entry FIFO.
- Shifts queued entries out one bit per request, so the host side needs only the fifo_req / fifo_bit / fifo_empty / fifo_oflow interface.
- Parametrised successor of the single-channel bit-serial result FIFO. Adds multi-channel round-robin collection, channel tagging, a level output and a clearable sticky overflow.

Parameters:
- NUM_CH, 4, number of hit sources; must be >= 2.
- WIDTH, 100, result bits per hit.
- DEPTH, 8, FIFO RAM entries; must be a power of 2, >= 2.
- CHW, $clog2(NUM_CH), channel tag width (derived; do not override).
- EW, CHW+WIDTH, serialised entry width (derived).

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous active-low reset.
- hit_valid  in  NUM_CH  per-channel single-cycle hit pulse.
- hit_data  in  NUM_CH*WIDTH  channel c data in bits [c*WIDTH +: WIDTH]; valid only while hit_valid[c] is high.
- fifo_req  in  1  advance one bit when high at a clk edge.
- fifo_oflow_clr  in  1  clears fifo_oflow.
- fifo_bit  out  1  current bit of the head entry, MSB first.
- fifo_empty  out  1  no head entry available.
- fifo_oflow  out  1  sticky: a hit was dropped.
- fifo_level  out  $clog2(DEPTH+2)  entries held (RAM + head).

Behaviour:
- Reset (rst_n low, asynchronous):
  - pending flags, RAM pointers, head_valid, bit counter, round-robin pointer and fifo_oflow all go to 0.
  - Outputs: fifo_empty=1, fifo_bit=0, fifo_level=0, fifo_oflow=0. Held entries are discarded.
- Capture:
  - Each channel has one pending register {valid, data}.
  - hit_valid[c] with pending[c] clear: latch data, set pending[c].
  - hit_valid[c] with pending[c] set: the new hit is dropped, fifo_oflow sets, and the existing pending data is kept.
  - If pending[c] is being drained in the same cycle, the new hit is accepted, not dropped.
- Drain:
  - Per cycle, at most one pending channel is written to RAM as entry {c[CHW-1:0], data}.
  - A write needs the RAM to be not full.
  - Channel choice is round-robin: search starts at rr_ptr; after a grant to channel c, rr_ptr becomes (c+1) mod NUM_CH.
  - RAM full: nothing drains, pending data is held, and no overflow is flagged until a further hit hits a set pending slot.
- Head:
  - A shift register of EW bits plus head_valid.
  - When head_valid=0 and the RAM is not empty, the next RAM entry loads into the head.
  - RAM write and head load may occur in the same cycle. Empty-RAM bypass is not provided: an entry always passes through RAM.
- Latency: hit sampled at edge E0 -> pending at E0 -> RAM write at E1 -> head loaded at E2. fifo_empty falls after E2 when uncontended.
- Readout:
  - fifo_bit = head[EW-1].
  - fifo_req high with head_valid=1: shift left by 1 and increment the bit counter.
  - At bit counter = EW-1: clear head_valid and reset the counter to 0; the next entry loads on the following edge.
  - fifo_req while fifo_empty: ignored; no state change and no flag.
- Status:
  - fifo_empty = !head_valid.
  - fifo_level = RAM occupancy + head_valid. Updates on the same edge as the write/load/pop.
- Overflow clear:
  - fifo_oflow_clr clears fifo_oflow.
  - If a drop occurs in the same cycle as the clear, set wins.
- RAM pointers are log2(DEPTH)+1 bits. Full = MSBs differ and the rest are equal. Empty = pointers equal. Wrap-around is natural modulo 2*DEPTH.
- Simultaneous hits on all channels are legal; they are drained over NUM_CH cycles in round-robin order.

Test Plan:
- Reset, then a hit on ch2 only (NUM_CH=4, WIDTH=100, data 100'h12345…) -> fifo_empty falls 3 edges later. With fifo_req held high for 102 cycles, fifo_bit streams 2'b10 then the data MSB first; fifo_empty rises after bit 102; fifo_level goes 1->0.
- All 4 channels pulse in the same cycle (rr_ptr=0) -> entries are read out in tag order 0,1,2,3. A second burst with rr_ptr=0 again gives the same order; a burst started after a ch1 grant gives order 2,3,0,1.
- Fill RAM (8) + head (1) with no fifo_req -> fifo_level=9. The next hit on ch0 sits in pending and fifo_oflow stays 0. A second ch0 hit sets fifo_oflow=1 and the first pending data survives and is read out later.
- fifo_oflow_clr asserted in the same cycle as a new drop -> fifo_oflow remains 1. Asserted alone -> fifo_oflow becomes 0.
- fifo_req toggled randomly while empty and during readout -> no spurious pops. Read data matches the model; pointers wrap across 3*DEPTH entries without loss.
- rst_n pulsed low mid-readout (bit 40 of an entry) -> fifo_empty=1, fifo_level=0 and fifo_oflow=0 immediately. After release, the first new hit reads out cleanly from bit 0.
